rng_word_arbiter: RTL and testbench

- Controller and arbiter for the 64-bit LUT-SR random-bit generator (rng[63:0], clock-enable input ce).
- After reset it runs the generator for a fixed warm-up so that output is discarded until the initial-state transients have flushed.
- It then shares the generator between N_REQ requesters with round-robin arbitration, delivering one fresh 64-bit word per grant.
- It owns the generator's ce, and no word is ever delivered twice.

---
 rtl/rng_word_arbiter_if.sv | 23 ++
 rtl/rng_word_arbiter.sv | 117 +++++++++++
 tb/tb_rng_word_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rng_word_arbiter_if.sv
// Handshake bundle between the rng_word_arbiter, its requesters and the
// LUT-SR generator it controls.
interface rng_word_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic             en;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [63:0]      rdata;
    logic             rng_ce;
    logic [63:0]      rng_word;
    logic             rng_ready;

    modport master (
        output en, req, rng_word,
        input  gnt, rdata, rng_ce, rng_ready
    );

    modport slave (
        input  en, req, rng_word,
        output gnt, rdata, rng_ce, rng_ready
    );
endinterface

// File: rtl/rng_word_arbiter.sv
// Warm-up controller and round-robin word arbiter for a 64-bit LUT-SR generator.
// Optional macro RNG_IDLE_STIR_EN keeps the generator free-running while serving.
module rng_word_arbiter #(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 4096
) (
    input  logic              clk,
    input  logic              reset,
    rng_word_arbiter_if.slave bus
);
    localparam int          PW        = $clog2(N_REQ);
    localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);

`ifdef RNG_IDLE_STIR_EN
    localparam logic IDLE_CE = 1'b1;
`else
    localparam logic IDLE_CE = 1'b0;
`endif

    typedef enum logic [0:0] {
        ST_WARMUP = 1'b0,
        ST_SERVE  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;

    logic [N_REQ-1:0] elig_s;
    logic             win_found_s;
    logic [PW-1:0]    win_idx_s;
    logic             ce_s;

    // Round-robin search: first eligible requester at or after the pointer.
    always_comb begin
        logic [PW-1:0] cand;
        logic          hit;
        elig_s      = bus.req & ~gnt_q;
        win_found_s = 1'b0;
        win_idx_s   = {PW{1'b0}};
        cand        = {PW{1'b0}};
        hit         = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand        = PW'((int'(ptr_q) + k) % N_REQ);
            hit         = !win_found_s && elig_s[cand];
            win_idx_s   = hit ? cand : win_idx_s;
            win_found_s = win_found_s | hit;
        end
    end

    // Next-state, grant and generator clock-enable decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = {N_REQ{1'b0}};
        rdata_d = rdata_q;
        ready_d = ready_q;
        ce_s    = 1'b0;
        case (state_q)
            ST_WARMUP: begin
                ce_s = 1'b1;
                if (cnt_q == WARM_LAST) begin
                    state_d = ST_SERVE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SERVE: begin
                if (bus.en && win_found_s) begin
                    ce_s    = 1'b1;
                    gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx_s;
                    rdata_d = bus.rng_word;
                    ptr_d   = (win_idx_s == PW'(N_REQ - 1)) ? {PW{1'b0}}
                                                            : win_idx_s + {{(PW-1){1'b0}}, 1'b1};
                end else begin
                    ce_s = IDLE_CE;
                end
            end
            default: begin
                state_d = ST_WARMUP;
                cnt_d   = 16'd0;
                ptr_d   = {PW{1'b0}};
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; the generator itself is never reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_WARMUP;
            cnt_q   <= 16'd0;
            ptr_q   <= {PW{1'b0}};
            gnt_q   <= {N_REQ{1'b0}};
            rdata_q <= 64'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
        end
    end

    // ce is held low during reset so that exactly WARMUP cycles follow release.
    assign bus.rng_ce    = ce_s & ~reset;
    assign bus.gnt       = gnt_q;
    assign bus.rdata     = rdata_q;
    assign bus.rng_ready = ready_q;
endmodule

// File: tb/tb_rng_word_arbiter.sv
// Directed/random bench for rng_word_arbiter with a behavioural generator and
// arbitration model; build with RNG_IDLE_STIR_EN to exercise the free-running mode.
module tb_rng_word_arbiter;
    localparam int          NR     = 4;
    localparam int          WU     = 16;
    localparam logic [63:0] SEED   = 64'h9E37_79B9_7F4A_7C15;
    localparam int          SEQ_N  = 2048;
`ifdef RNG_IDLE_STIR_EN
    localparam logic        STIR   = 1'b1;
`else
    localparam logic        STIR   = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    rng_word_arbiter_if #(.N_REQ(NR)) bus ();

    rng_word_arbiter #(.N_REQ(NR), .WARMUP(WU)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] xs64(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    // Stand-in LUT-SR generator: advances only when the DUT enables it.
    logic [63:0] gen_r = SEED;
    always @(posedge clk) if (bus.rng_ce) gen_r <= xs64(gen_r);
    assign bus.rng_word = gen_r;

    // Reference model: generator word table indexed by number of ce cycles.
    logic [63:0] seq [SEQ_N];
    int          m_gen;
    int          m_warm_done;
    logic        m_serve;
    int          m_ptr;
    logic [3:0]  m_gnt;
    logic [63:0] m_rdata;
    logic        m_ready;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_warm_done = 0;
        m_serve     = 1'b0;
        m_ptr       = 0;
        m_gnt       = 4'd0;
        m_rdata     = 64'd0;
        m_ready     = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".gnt"},   {60'd0, bus.gnt}, {60'd0, m_gnt});
        chk({tag, ".rdata"}, bus.rdata, m_rdata);
        chk({tag, ".ready"}, {63'd0, bus.rng_ready}, {63'd0, m_ready});
    endtask

    // One clock cycle: drive inputs, check ce, advance model, check registered outputs.
    task automatic cycle(input logic [3:0] r, input logic e, input string tag);
        int   w;
        logic exp_ce;
        logic [3:0] elig;
        bus.req = r;
        bus.en  = e;
        #1;
        w = -1;
        if (!m_serve) begin
            exp_ce = 1'b1;
        end else begin
            elig = r & ~m_gnt;
            if (e) begin
                for (int k = 0; k < NR; k++)
                    if (w < 0 && elig[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            end
            exp_ce = (w >= 0) ? 1'b1 : STIR;
        end
        chk({tag, ".ce"}, {63'd0, bus.rng_ce}, {63'd0, exp_ce});
        @(posedge clk);
        #1;
        if (!m_serve) begin
            m_warm_done++;
            if (m_warm_done == WU) begin
                m_serve = 1'b1;
                m_ready = 1'b1;
            end
        end else if (w >= 0) begin
            m_gnt   = 4'b0001 << w;
            m_rdata = seq[m_gen];
            m_ptr   = (w + 1) % NR;
        end else begin
            m_gnt = 4'd0;
        end
        if (exp_ce) m_gen++;
        if (m_gen >= SEQ_N) begin
            $display("FAIL model_table observed=%0d expected<%0d", m_gen, SEQ_N);
            $fatal(1, "generator table exhausted");
        end
        check_outputs(tag);
    endtask

    initial begin
        int waited;
        seq[0] = SEED;
        for (int i = 1; i < SEQ_N; i++) seq[i] = xs64(seq[i-1]);
        m_gen = 0;
        model_reset();

        reset   = 1'b1;
        bus.req = 4'd0;
        bus.en  = 1'b0;
        #1;
        check_outputs("reset0");
        chk("reset0.ce", {63'd0, bus.rng_ce}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < WU; i++) cycle(4'b1111, 1'b1, "warmup");
        for (int i = 0; i < 12; i++) cycle(4'b1111, 1'b1, "rr");
        for (int i = 0; i < 8; i++)  cycle(4'b0100, 1'b1, "single2");
        for (int i = 0; i < 5; i++)  cycle(4'b0010, 1'b0, "en_low");
        for (int i = 0; i < 3; i++)  cycle(4'b0010, 1'b1, "en_back");
        for (int i = 0; i < 150; i++)
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0), "rand");

        waited = 0;
        while (m_gnt != 4'b1000 && waited < 8) begin
            cycle(4'b1111, 1'b1, "to_gnt3");
            waited++;
        end
        chk("gnt3_reached", {60'd0, m_gnt}, {60'd0, 4'b1000});
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst.ce", {63'd0, bus.rng_ce}, 64'd0);
        @(posedge clk); #1;
        check_outputs("held_rst");
        reset = 1'b0;
        for (int i = 0; i < WU; i++) cycle(4'b1111, 1'b1, "warmup2");
        for (int i = 0; i < 6; i++)  cycle(4'b1111, 1'b1, "rr2");

        for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b1, "idle");
        cycle(4'b0001, 1'b1, "after_idle");
        for (int i = 0; i < 3; i++)  cycle(4'b0000, 1'b1, "tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
